// File: rtl/c499_resp_misr.sv
// Response compactor for the key-locked c499 netlist: folds each valid output vector into a MISR and
// compares the final signature with a golden value. Optional abort support via C499_MISR_ABORT_EN.
module c499_resp_misr #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] POLY         = WIDTH'(32'h04C11DB7),
    parameter logic [WIDTH-1:0] SEED         = WIDTH'(32'hFFFFFFFF),
    parameter int unsigned      NUM_PATTERNS = 1024,
    parameter int unsigned      CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
    input  logic [WIDTH-1:0] golden_sig,
`ifdef C499_MISR_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] pattern_cnt
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] next_sig;
    logic             last_pattern;

    // Shift left, fold the outgoing MSB back through the polynomial taps, then mix in the response.
    always_comb begin
        next_sig = {signature[WIDTH-2:0], 1'b0}
                 ^ (signature[WIDTH-1] ? POLY : {WIDTH{1'b0}})
                 ^ resp_data;
    end

    assign last_pattern = resp_valid && (pattern_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            signature   <= SEED;
            pattern_cnt <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
`ifdef C499_MISR_ABORT_EN
            aborted     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RUN;
                        signature   <= SEED;
                        pattern_cnt <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
`ifdef C499_MISR_ABORT_EN
                        aborted     <= 1'b0;
`endif
                    end
                end
                RUN: begin
`ifdef C499_MISR_ABORT_EN
                    // Abort beats a coincident final pattern: nothing is compacted.
                    if (abort) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        aborted <= 1'b1;
                    end else begin
`else
                    begin
`endif
                        if (resp_valid) begin
                            signature   <= next_sig;
                            pattern_cnt <= pattern_cnt + CNT_W'(1);
                            if (last_pattern) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                pass  <= (next_sig == golden_sig);
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c499_resp_misr.sv
// Scoreboard bench for c499_resp_misr: a 4-pattern zero-seed instance and a 1-pattern MSB-seed instance.
module tb_c499_resp_misr;

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 16;
    localparam logic [W-1:0] POLY_V = 32'h04C11DB7;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  resp_data;
    logic          start_a, valid_a, start_b, valid_b;
    logic [W-1:0]  golden_a, golden_b;
    logic          busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [W-1:0]  sig_a, sig_b;
    logic [CW-1:0] cnt_a, cnt_b;
`ifdef C499_MISR_ABORT_EN
    logic          abort_a, abort_b, aborted_a, aborted_b;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_sig;
    int           m_cnt;
    logic         m_run;

    always #5 clk = ~clk;

    c499_resp_misr #(.WIDTH(W), .POLY(POLY_V), .SEED(32'h0), .NUM_PATTERNS(4), .CNT_W(CW)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .resp_valid(valid_a), .resp_data(resp_data),
        .golden_sig(golden_a),
`ifdef C499_MISR_ABORT_EN
        .abort(abort_a), .aborted(aborted_a),
`endif
        .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a), .pattern_cnt(cnt_a)
    );

    c499_resp_misr #(.WIDTH(W), .POLY(POLY_V), .SEED(32'h80000000), .NUM_PATTERNS(1), .CNT_W(CW)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .resp_valid(valid_b), .resp_data(resp_data),
        .golden_sig(golden_b),
`ifdef C499_MISR_ABORT_EN
        .abort(abort_b), .aborted(aborted_b),
`endif
        .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b), .pattern_cnt(cnt_b)
    );

    function automatic logic [W-1:0] misr_step(input logic [W-1:0] s, input logic [W-1:0] d);
        logic [W-1:0] r;
        r = s << 1;
        if (s[W-1]) r = r ^ POLY_V;
        return r ^ d;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one valid pattern into instance A and score the resulting signature.
    task automatic send_a(input logic [W-1:0] d);
        @(negedge clk);
        start_a = 1'b0; valid_a = 1'b1; resp_data = d;
        if (m_run) begin
            m_sig = misr_step(m_sig, d);
            m_cnt++;
            exp_q.push_back(m_sig);
            if (m_cnt == 4) m_run = 1'b0;
        end
        @(posedge clk); #1;
        if (exp_q.size() > 0) check("sig", sig_a, exp_q.pop_front());
        else check("sig_hold", sig_a, m_sig);
        check("cnt", W'(cnt_a), W'(m_cnt));
    endtask

    task automatic idle_a(input logic st);
        @(negedge clk);
        start_a = st; valid_a = 1'b0; resp_data = $urandom;
        @(posedge clk); #1;
        start_a = 1'b0;
        check("idle_sig", sig_a, m_sig);
        check("idle_busy", W'(busy_a), W'(m_run));
    endtask

    task automatic start_run_a(input logic [W-1:0] g);
        @(negedge clk);
        start_a = 1'b1; valid_a = 1'b0; golden_a = g;
        @(posedge clk); #1;
        start_a = 1'b0;
        m_sig = '0; m_cnt = 0; m_run = 1'b1;
        check("start_busy", W'(busy_a), 1);
        check("start_done", W'(done_a), 0);
        check("start_sig", sig_a, 0);
        check("start_cnt", W'(cnt_a), 0);
    endtask

    task automatic check_done_a(input logic exp_pass);
        check("done", W'(done_a), 1);
        check("busy_off", W'(busy_a), 0);
        check("pass", W'(pass_a), W'(exp_pass));
        check("final_cnt", W'(cnt_a), 4);
        check("final_sig", sig_a, 32'h2);
    endtask

    initial begin
        rst = 1'b1; resp_data = '0;
        start_a = 0; valid_a = 0; start_b = 0; valid_b = 0;
        golden_a = '0; golden_b = '0;
`ifdef C499_MISR_ABORT_EN
        abort_a = 0; abort_b = 0;
`endif
        m_sig = '0; m_cnt = 0; m_run = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sig_a", sig_a, 32'h0);
        check("rst_sig_b", sig_b, 32'h80000000);
        check("rst_cnt", W'(cnt_a), 0);
        check("rst_busy", W'(busy_a), 0);
        check("rst_done", W'(done_a), 0);
        check("rst_pass", W'(pass_a), 0);
        @(negedge clk); rst = 1'b0;

        // Back-to-back patterns 1..4, signature 1,0,3,2, matching golden.
        start_run_a(32'h2);
        send_a(32'h1); send_a(32'h2); send_a(32'h3); send_a(32'h4);
        check_done_a(1'b1);

        // Same run with a wrong golden, then random traffic must not disturb the result.
        start_run_a(32'h3);
        send_a(32'h1); send_a(32'h2); send_a(32'h3); send_a(32'h4);
        check_done_a(1'b0);
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) != 0) send_a($urandom);
            else idle_a(1'b0);
        end
        check_done_a(1'b0);

        // Gapped valids with start pulses while running: no restart.
        start_run_a(32'h2);
        for (int i = 1; i <= 4; i++) begin
            send_a(W'(i));
            if (i < 4) begin
                idle_a(1'b1);
                idle_a(1'b0);
            end
        end
        check_done_a(1'b1);

        // Reset mid-run discards the run; a fresh run still gives the reference result.
        start_run_a(32'h2);
        send_a(32'h1); send_a(32'h2);
        @(negedge clk); rst = 1'b1; valid_a = 1'b0;
        @(posedge clk); #1;
        m_sig = '0; m_cnt = 0; m_run = 1'b0;
        check("mid_rst_sig", sig_a, 32'h0);
        check("mid_rst_cnt", W'(cnt_a), 0);
        check("mid_rst_done", W'(done_a), 0);
        check("mid_rst_busy", W'(busy_a), 0);
        @(negedge clk); rst = 1'b0;
        start_run_a(32'h2);
        send_a(32'h1); send_a(32'h2); send_a(32'h3); send_a(32'h4);
        check_done_a(1'b1);

        // Single-pattern run exercising the feedback taps.
        @(negedge clk); start_b = 1'b1; golden_b = POLY_V;
        @(negedge clk); start_b = 1'b0; valid_b = 1'b1; resp_data = '0;
        @(negedge clk); valid_b = 1'b0;
        check("b_sig", sig_b, misr_step(32'h80000000, 32'h0));
        check("b_done", W'(done_b), 1);
        check("b_pass", W'(pass_b), 1);
        check("b_cnt", W'(cnt_b), 1);

`ifdef C499_MISR_ABORT_EN
        // Abort after two patterns freezes state and forces a failing result.
        start_run_a(32'h0);
        send_a(32'h1); send_a(32'h2);
        @(negedge clk); valid_a = 1'b0; abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        m_run = 1'b0;
        check("ab_done", W'(done_a), 1);
        check("ab_aborted", W'(aborted_a), 1);
        check("ab_pass", W'(pass_a), 0);
        check("ab_cnt", W'(cnt_a), 2);
        check("ab_sig", sig_a, 32'h0);
        start_run_a(32'h2);
        check("ab_clear", W'(aborted_a), 0);
`endif

        check("queue_empty", W'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
